obstacle_edge_builder: RTL and testbench

Receiving end of the environment vertex stream. Consumes the per-frame `valid`/`x`/`y`/`done` vertex stream produced by the environment manager and rebuilds polygon edges, closing each polygon back to its first vertex. Edges are buffered in a small FIFO and presented on a ready/valid interface to downstream collision and rendering logic. A frame-complete flag is raised only after every edge of the frame has been accepted.

---
 rtl/env_pkg.sv | 25 ++
 rtl/obstacle_edge_builder_if.sv | 47 ++++
 rtl/edge_fifo.sv | 68 ++++++
 rtl/obstacle_edge_builder.sv | 199 +++++++++++++++++++
 tb/tb_obstacle_edge_builder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/env_pkg.sv
// Shared types for the environment vertex stream consumers: the default
// coordinate width, the edge record and the edge builder state encoding.
package env_pkg;

  localparam int WORLD_BITS = 32;

  typedef struct packed {
    logic signed [WORLD_BITS-1:0] x0;
    logic signed [WORLD_BITS-1:0] y0;
    logic signed [WORLD_BITS-1:0] x1;
    logic signed [WORLD_BITS-1:0] y1;
  } edge_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } edge_builder_state;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/obstacle_edge_builder_if.sv
// Bundle of the vertex stream inputs and the edge ready/valid outputs of
// obstacle_edge_builder. master = stream source / edge consumer side,
// slave = the edge builder itself. OBSTACLE_STATS_EN adds the counters.
interface obstacle_edge_builder_if
  import env_pkg::*;
#(
  parameter int WORLD_BITS = env_pkg::WORLD_BITS
) ();

  logic                         start_in;
  logic                         vtx_valid_in;
  logic signed [WORLD_BITS-1:0] vtx_x_in;
  logic signed [WORLD_BITS-1:0] vtx_y_in;
  logic                         env_done_in;

  logic                         edge_valid_out;
  logic                         edge_ready_in;
  logic signed [WORLD_BITS-1:0] edge_x0_out;
  logic signed [WORLD_BITS-1:0] edge_y0_out;
  logic signed [WORLD_BITS-1:0] edge_x1_out;
  logic signed [WORLD_BITS-1:0] edge_y1_out;
  logic                         frame_done_out;
  logic                         overflow_out;
`ifdef OBSTACLE_STATS_EN
  logic [15:0]                  polygon_count_out;
  logic [15:0]                  edge_count_out;
`endif

  modport master (
    output start_in, vtx_valid_in, vtx_x_in, vtx_y_in, env_done_in, edge_ready_in,
    input  edge_valid_out, edge_x0_out, edge_y0_out, edge_x1_out, edge_y1_out,
    input  frame_done_out, overflow_out
`ifdef OBSTACLE_STATS_EN
    , input polygon_count_out, edge_count_out
`endif
  );

  modport slave (
    input  start_in, vtx_valid_in, vtx_x_in, vtx_y_in, env_done_in, edge_ready_in,
    output edge_valid_out, edge_x0_out, edge_y0_out, edge_x1_out, edge_y1_out,
    output frame_done_out, overflow_out
`ifdef OBSTACLE_STATS_EN
    , output polygon_count_out, edge_count_out
`endif
  );

endinterface

// File: rtl/edge_fifo.sv
// First-word-fall-through edge buffer. The head is visible on rdata the
// cycle after it is written. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; flush empties it synchronously.
module edge_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Empty head reads as zero so the coordinate outputs are defined out of reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Accept/advance decisions for both pointers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en) && !flush;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: clocked state uses non-blocking assignments; combinational logic uses blocking.
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/obstacle_edge_builder.sv
// Rebuilds polygon edges from the environment vertex stream, closing each
// polygon of 3+ vertices back to its first vertex, buffers them in an
// edge_fifo and pulses frame_done_out once the frame's edges are all taken.
// Optional: define OBSTACLE_STATS_EN for polygon/edge counters.
module obstacle_edge_builder
  import env_pkg::*;
#(
  parameter int WORLD_BITS = env_pkg::WORLD_BITS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  obstacle_edge_builder_if.slave  eb
);

  localparam int EW = 4 * WORLD_BITS;

  typedef logic signed [WORLD_BITS-1:0] coord_t;

  edge_builder_state state_q, state_d;
  logic              open_q, open_d;      // a polygon has started and not yet closed
  logic              pend_q, pend_d;      // env_done arrived with a vertex; close next cycle
  logic              ovf_q, ovf_d;
  coord_t            first_x_q, first_x_d;
  coord_t            first_y_q, first_y_d;
  coord_t            prev_x_q, prev_x_d;
  coord_t            prev_y_q, prev_y_d;
  logic [15:0]       nverts_q, nverts_d;

  logic              push;
  logic              push_ok;
  logic              pop;
  logic              flush;
  logic              full;
  logic              empty;
  logic              close_now;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head_data;

  edge_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wdata  (push_data),
    .rdata  (head_data),
    .full   (full),
    .empty  (empty)
  );

  assign pop     = !empty && eb.edge_ready_in;
  assign push_ok = push && (!full || pop);

  // Next-state: frame FSM, polygon tracking and edge generation.
  always_comb begin
    state_d   = state_q;
    open_d    = open_q;
    pend_d    = pend_q;
    first_x_d = first_x_q;
    first_y_d = first_y_q;
    prev_x_d  = prev_x_q;
    prev_y_d  = prev_y_q;
    nverts_d  = nverts_q;
    push      = 1'b0;
    push_data = '0;
    flush     = 1'b0;
    close_now = 1'b0;

    case (state_q)
      RUN: begin
        if (pend_q) begin
          // Deferred close for a done that arrived together with a vertex.
          close_now = open_q;
          pend_d    = 1'b0;
          state_d   = DRAIN;
        end else if (eb.vtx_valid_in) begin
          if (!open_q) begin
            first_x_d = eb.vtx_x_in;
            first_y_d = eb.vtx_y_in;
            nverts_d  = 16'd1;
            open_d    = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {prev_x_q, prev_y_q, eb.vtx_x_in, eb.vtx_y_in};
            nverts_d  = sat_inc16(nverts_q);
          end
          prev_x_d = eb.vtx_x_in;
          prev_y_d = eb.vtx_y_in;
          if (eb.env_done_in) begin
            pend_d = 1'b1;
          end
        end else begin
          close_now = open_q;
          if (eb.env_done_in) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    // Closing rule: only 3+ vertex polygons need an edge back to the start.
    if (close_now) begin
      open_d = 1'b0;
      if (nverts_q >= 16'd3) begin
        push      = 1'b1;
        push_data = {prev_x_q, prev_y_q, first_x_q, first_y_q};
      end
    end

    // Frame start overrides everything: discard the open polygon and the buffer.
    if (eb.start_in) begin
      state_d = RUN;
      flush   = 1'b1;
      open_d  = 1'b0;
      pend_d  = 1'b0;
      push    = 1'b0;
    end

    ovf_d = eb.start_in ? 1'b0 : (ovf_q | (push && !push_ok));
  end

  // State and tracking registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      open_q    <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      first_x_q <= '0;
      first_y_q <= '0;
      prev_x_q  <= '0;
      prev_y_q  <= '0;
      nverts_q  <= '0;
    end else begin
      state_q   <= state_d;
      open_q    <= open_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      first_x_q <= first_x_d;
      first_y_q <= first_y_d;
      prev_x_q  <= prev_x_d;
      prev_y_q  <= prev_y_d;
      nverts_q  <= nverts_d;
    end
  end

  assign eb.edge_valid_out = !empty;
  assign {eb.edge_x0_out, eb.edge_y0_out, eb.edge_x1_out, eb.edge_y1_out} = head_data;
  assign eb.frame_done_out = (state_q == DRAIN) && empty;
  assign eb.overflow_out   = ovf_q;

`ifdef OBSTACLE_STATS_EN
  logic [15:0] poly_cnt_q, poly_cnt_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;

  // Counter updates: closed polygons of 2+ vertices and edges actually stored.
  always_comb begin
    poly_cnt_d = poly_cnt_q;
    edge_cnt_d = edge_cnt_q;
    if (eb.start_in) begin
      poly_cnt_d = '0;
      edge_cnt_d = '0;
    end else begin
      if (close_now && (nverts_q >= 16'd2)) begin
        poly_cnt_d = sat_inc16(poly_cnt_q);
      end
      if (push_ok) begin
        edge_cnt_d = sat_inc16(edge_cnt_q);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      poly_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      poly_cnt_q <= poly_cnt_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign eb.polygon_count_out = poly_cnt_q;
  assign eb.edge_count_out    = edge_cnt_q;
`endif

endmodule

// File: tb/tb_obstacle_edge_builder.sv
// Self-checking bench for obstacle_edge_builder: a vector table for the
// square and two-polygon frames, hand-written backpressure, lone-vertex and
// mid-frame reset sequences, and a scoreboard queue of expected edges that a
// negedge monitor compares against every accepted FIFO head.
module tb_obstacle_edge_builder;
  import env_pkg::*;

  localparam int DEPTH = 8;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  obstacle_edge_builder_if #(.WORLD_BITS(WORLD_BITS)) bus ();

  obstacle_edge_builder #(
    .WORLD_BITS (WORLD_BITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .eb     (bus)
  );

  int    n_checks  = 0;
  int    n_errors  = 0;
  int    pop_count = 0;
  int    fd_count  = 0;
  edge_t exp_q[$];

  typedef struct {
    logic  start;
    logic  valid;
    int    x;
    int    y;
    logic  done;
    logic  push;
    edge_t e;
    logic  exp_valid;
    logic  exp_fd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic edge_t mk(input int x0, input int y0, input int x1, input int y1);
    edge_t e;
    e.x0 = x0;
    e.y0 = y0;
    e.x1 = x1;
    e.y1 = y1;
    return e;
  endfunction

  task automatic add(input logic s, input logic v, input int x, input int y, input logic d,
                     input logic p, input edge_t e, input logic ev, input logic efd);
    vec_t r;
    r.start = s; r.valid = v; r.x = x; r.y = y; r.done = d;
    r.push = p; r.e = e; r.exp_valid = ev; r.exp_fd = efd;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic s, input logic v, input int x, input int y, input logic d);
    bus.start_in     = s;
    bus.vtx_valid_in = v;
    bus.vtx_x_in     = x;
    bus.vtx_y_in     = y;
    bus.env_done_in  = d;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].done);
      if (vecs[i].push) exp_q.push_back(vecs[i].e);
      tick();
      check($sformatf("row%0d_valid", i), bus.edge_valid_out, vecs[i].exp_valid);
      check($sformatf("row%0d_fd", i), bus.frame_done_out, vecs[i].exp_fd);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  // Monitor: scoreboard compare on every pop, hold-while-stalled, frame_done rules.
  initial begin
    edge_t head;
    edge_t stall_data;
    logic  stall_prev;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk_in);
      head = {bus.edge_x0_out, bus.edge_y0_out, bus.edge_x1_out, bus.edge_y1_out};
      if (rst_in !== 1'b0) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", bus.edge_valid_out, 1'b1);
          check("stall_hold", head, stall_data);
        end
        if (bus.frame_done_out) begin
          fd_count++;
          check("fd_after_last_pop", bus.edge_valid_out, 1'b0);
        end
        if (bus.edge_valid_out && bus.edge_ready_in) begin
          pop_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_edge: got %h expected no edge", head);
          end else begin
            check("edge_data", head, exp_q.pop_front());
          end
        end
        stall_prev = bus.edge_valid_out && !bus.edge_ready_in;
        stall_data = head;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    fd0;
    int    pops0;
    int    k;
    edge_t held;

    rst_in = 1'b1;
    drive(0, 0, 0, 0, 0);
    bus.edge_ready_in = 1'b0;

    // Square (rows 0-7) then triangle + 2-gon ending with env_done (rows 8-16).
    add(1, 0,  0,  0, 0, 0, '0,                    0, 0);
    add(0, 1,  0,  0, 0, 0, '0,                    0, 0);
    add(0, 1, 10,  0, 0, 1, mk(0, 0, 10, 0),       1, 0);
    add(0, 1, 10, 10, 0, 1, mk(10, 0, 10, 10),     1, 0);
    add(0, 1,  0, 10, 0, 1, mk(10, 10, 0, 10),     1, 0);
    add(0, 0,  0,  0, 0, 1, mk(0, 10, 0, 0),       1, 0);
    add(0, 0,  0,  0, 1, 0, '0,                    0, 1);
    add(0, 0,  0,  0, 0, 0, '0,                    0, 0);
    add(1, 0,  0,  0, 0, 0, '0,                    0, 0);
    add(0, 1,  1,  1, 0, 0, '0,                    0, 0);
    add(0, 1,  5,  1, 0, 1, mk(1, 1, 5, 1),        1, 0);
    add(0, 1,  3,  4, 0, 1, mk(5, 1, 3, 4),        1, 0);
    add(0, 0,  0,  0, 0, 1, mk(3, 4, 1, 1),        1, 0);
    add(0, 1, -2, -2, 0, 0, '0,                    0, 0);
    add(0, 1,  7, -2, 0, 1, mk(-2, -2, 7, -2),     1, 0);
    add(0, 0,  0,  0, 1, 0, '0,                    0, 1);
    add(0, 0,  0,  0, 0, 0, '0,                    0, 0);

    // Reset state.
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid", bus.edge_valid_out, 1'b0);
    check("rst_fd", bus.frame_done_out, 1'b0);
    check("rst_ovf", bus.overflow_out, 1'b0);
    check("rst_data", {bus.edge_x0_out, bus.edge_y0_out, bus.edge_x1_out, bus.edge_y1_out}, '0);
    #2 rst_in = 1'b0;
    tick();

    // Square and two-polygon frames with the consumer always ready.
    bus.edge_ready_in = 1'b1;
    fd0   = fd_count;
    pops0 = pop_count;
    run_rows(0, 7);
    check("sq_pops", pop_count - pops0, 4);
    run_rows(8, 16);
    check("two_poly_pops", pop_count - pops0, 8);
    check("two_frames_fd", fd_count - fd0, 2);
    check("sb_empty_1", exp_q.size(), 0);
`ifdef OBSTACLE_STATS_EN
    check("stats_poly", bus.polygon_count_out, 16'd2);
    check("stats_edge", bus.edge_count_out, 16'd4);
`endif

    // Backpressure: 12-vertex polygon into an 8-deep FIFO with ready low.
    bus.edge_ready_in = 1'b0;
    drive(1, 0, 0, 0, 0);
    tick();
`ifdef OBSTACLE_STATS_EN
    check("stats_clr_poly", bus.polygon_count_out, 16'd0);
    check("stats_clr_edge", bus.edge_count_out, 16'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, i * 3, -i, 0);
      if (i >= 1 && i <= DEPTH) exp_q.push_back(mk((i - 1) * 3, -(i - 1), i * 3, -i));
      tick();
      if (i == DEPTH) check("bp_ovf_at_full", bus.overflow_out, 1'b0);
      if (i == DEPTH + 1) check("bp_ovf_on_drop", bus.overflow_out, 1'b1);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("bp_fd_blocked", bus.frame_done_out, 1'b0);
    held = {bus.edge_x0_out, bus.edge_y0_out, bus.edge_x1_out, bus.edge_y1_out};
    check("bp_head", held, mk(0, 0, 3, -1));
    repeat (3) tick();
    check("bp_head_held", {bus.edge_x0_out, bus.edge_y0_out, bus.edge_x1_out, bus.edge_y1_out}, held);
    fd0   = fd_count;
    pops0 = pop_count;
    bus.edge_ready_in = 1'b1;
    k = 0;
    while (fd_count == fd0 && k < 40) begin
      tick();
      k++;
    end
    check("bp_fd_once", fd_count - fd0, 1);
    check("bp_pops", pop_count - pops0, DEPTH);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_ovf_sticky", bus.overflow_out, 1'b1);
`ifdef OBSTACLE_STATS_EN
    check("bp_stats_edge", bus.edge_count_out, 16'd8);
    check("bp_stats_poly", bus.polygon_count_out, 16'd1);
`endif

    // Lone vertex: no edges, frame_done one cycle after done.
    tick();
    fd0   = fd_count;
    pops0 = pop_count;
    drive(1, 0, 0, 0, 0);
    tick();
    check("lone_ovf_cleared", bus.overflow_out, 1'b0);
    drive(0, 1, 4, 4, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("lone_fd", bus.frame_done_out, 1'b1);
    check("lone_valid", bus.edge_valid_out, 1'b0);
    tick();
    check("lone_fd_pulse", bus.frame_done_out, 1'b0);
    check("lone_no_edges", pop_count - pops0, 0);
    check("lone_fd_count", fd_count - fd0, 1);

    // Mid-frame reset with three edges buffered, then a fresh square.
    bus.edge_ready_in = 1'b0;
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0);   tick();
    drive(0, 1, 10, 0, 0);  tick();
    drive(0, 1, 10, 10, 0); tick();
    drive(0, 1, 0, 10, 0);  tick();
    check("pre_rst_valid", bus.edge_valid_out, 1'b1);
    #2 rst_in = 1'b1;
    #1;
    check("rst_async_valid", bus.edge_valid_out, 1'b0);
    check("rst_async_data", {bus.edge_x0_out, bus.edge_y0_out, bus.edge_x1_out, bus.edge_y1_out}, '0);
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b0;
    tick();
    check("post_rst_valid", bus.edge_valid_out, 1'b0);
    bus.edge_ready_in = 1'b1;
    pops0 = pop_count;
    run_rows(0, 7);
    check("post_rst_pops", pop_count - pops0, 4);
    check("sb_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
